// File: rtl/spi_cmd_sequencer.sv
// Command sequencer in front of the 16-bit SPI master: buffers {rd, data} commands in a FIFO,
// launches one frame at a time and returns one response per command (read data or timeout).
module spi_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYC     = 4000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_rd,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_en,
  output logic        spi_wr_ctrl,
  output logic [15:0] spi_sdata,
  input  logic        spi_csn,
  input  logic        spi_done,
  input  logic [15:0] spi_rdata,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TO_CYC) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_XFER   = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // cmd_valid/cmd_ready: a command moves when both are high at a sys_clk edge; cmd_rd and
  // cmd_data must be stable while cmd_valid is high. rsp_valid is a single-cycle pulse that
  // the consumer cannot stall.

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, empty, push, pop;
  logic [16:0]   head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_rise, timeout;
  logic          en_q, en_d;
  logic          wr_ctrl_q, wr_ctrl_d;
  logic [15:0]   sdata_q, sdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_rd_q, rsp_rd_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_rd, cmd_data};
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // A long high level of spi_done must complete exactly one frame.
  assign done_rise = spi_done && !done_q;
  // >= keeps the exit reachable even if the counter ever steps past the limit.
  assign timeout   = (cnt_q >= TO_LAST);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      wr_ctrl_q   <= 1'b0;
      sdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= spi_done;
      en_q        <= en_d;
      wr_ctrl_q   <= wr_ctrl_d;
      sdata_q     <= sdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    wr_ctrl_d   = wr_ctrl_q;
    sdata_d     = sdata_q;
    rsp_valid_d = 1'b0;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          wr_ctrl_d = head[16];
          sdata_d   = head[16] ? 16'h0000 : head[15:0];
          en_d      = 1'b1;
          cnt_d     = '0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH, S_XFER: begin
        cnt_d = cnt_q + CW'(1);
        // The master has no accept signal: chip select falling is the launch acknowledge.
        if (state_q == S_XFER && done_rise) begin
          rsp_valid_d = 1'b1;
          rsp_rd_d    = wr_ctrl_q;
          rsp_data_d  = wr_ctrl_q ? spi_rdata : 16'h0000;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timeout) begin
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = wr_ctrl_q;
          rsp_data_d  = 16'h0000;
          rsp_err_d   = 1'b1;
          state_d     = S_ERR;
        end else if (state_q == S_LAUNCH && !spi_csn) begin
          en_d    = 1'b0;
          state_d = S_XFER;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = !full;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign spi_en      = en_q;
  assign spi_wr_ctrl = wr_ctrl_q;
  assign spi_sdata   = sdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a behavioural SPI master stub and a response monitor.
module tb_spi_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic        sys_clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_rd;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_rd, rsp_err, busy;
  logic [15:0] rsp_data;
  logic        spi_en, spi_wr_ctrl, spi_csn, spi_done;
  logic [15:0] spi_sdata, spi_rdata;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  spi_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TO_CYC(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .spi_en(spi_en), .spi_wr_ctrl(spi_wr_ctrl), .spi_sdata(spi_sdata),
    .spi_csn(spi_csn), .spi_done(spi_done), .spi_rdata(spi_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #10 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // master stub: drives its outputs 1 time unit after posedge
  int          stub_csn_dly  = 2;
  int          stub_xfer_len = 5;
  int          stub_done_len = 1;
  bit          stub_hang     = 1'b0;
  bit          stub_busy     = 1'b0;
  int          frames        = 0;
  logic [16:0] frame_q[$];
  logic [15:0] rd_src_q[$];

  initial begin
    spi_csn = 1'b1; spi_done = 1'b0; spi_rdata = 16'h0000;
    forever begin
      @(negedge sys_clk);
      if (spi_en === 1'b1 && !stub_hang) begin
        stub_busy = 1'b1;
        repeat (stub_csn_dly) @(posedge sys_clk);
        #1;
        spi_csn = 1'b0;
        frames++;
        frame_q.push_back({spi_wr_ctrl, spi_sdata});
        repeat (stub_xfer_len) @(posedge sys_clk);
        #1;
        spi_rdata = (spi_wr_ctrl && rd_src_q.size() > 0) ? rd_src_q.pop_front() : 16'hDEAD;
        spi_done  = 1'b1;
        repeat (stub_done_len) @(posedge sys_clk);
        #1;
        spi_done = 1'b0;
        spi_csn  = 1'b1;
        repeat (2) @(posedge sys_clk);
        stub_busy = 1'b0;
      end
    end
  end

  // monitor: responses, spi_en run lengths, FIFO occupancy model
  logic [17:0] obs_q[$];
  int en_run = 0, last_en_len = 0, en_rises = 0;
  int occ = 0, ready_bad = 0, ready_low = 0;
  bit en_prev = 1'b0, acc_pend = 1'b0, rst_pend = 1'b0, occ_chk = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    #1;
    if (rsp_valid === 1'b1) obs_q.push_back({rsp_err, rsp_rd, rsp_data});
    if (spi_en === 1'b1) begin
      en_run++;
      if (!en_prev) en_rises++;
    end else if (en_prev) begin
      last_en_len = en_run;
      en_run = 0;
    end
    if (rst_pend) occ = 0;
    else begin
      if (acc_pend) occ++;
      if (spi_en === 1'b1 && !en_prev) occ--;
    end
    if (occ_chk) begin
      if (cmd_ready !== (occ != DEPTH)) ready_bad++;
      if (cmd_ready === 1'b0) ready_low++;
    end
    acc_pend = (cmd_valid === 1'b1) && (cmd_ready === 1'b1) && (rst !== 1'b1);
    rst_pend = (rst === 1'b1);
    en_prev  = (spi_en === 1'b1);
  end

  // driver tasks (entered and left on a negedge)
  task automatic push_cmd(input logic rd, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_rd = rd; cmd_data = d;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_data = 16'h0000;
  endtask

  task automatic wait_rsps(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic wait_csn_low(output bit seen);
    int k = 0;
    while (spi_csn !== 1'b0 && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    seen = (spi_csn === 1'b0);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({spi_en, spi_wr_ctrl, spi_sdata} !== 18'h0) begin
      errors++; $display("FAIL reset_spi_out: got %h expected 0", {spi_en, spi_wr_ctrl, spi_sdata});
    end
    checks++;
    if ({rsp_valid, rsp_rd, rsp_err, rsp_data} !== 19'h0) begin
      errors++; $display("FAIL reset_rsp_out: got %h expected 0", {rsp_valid, rsp_rd, rsp_err, rsp_data});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write();
    bit seen;
    obs_q.delete(); frame_q.delete();
    stub_csn_dly = 2; stub_xfer_len = 5; stub_done_len = 1;
    push_cmd(1'b0, 16'hA55A);
    checks++;
    if (spi_en !== 1'b0) begin errors++; $display("FAIL write_en_early: got %b expected 0", spi_en); end
    @(negedge sys_clk);
    checks++;
    if ({spi_en, spi_wr_ctrl, spi_sdata} !== {1'b1, 1'b0, 16'hA55A}) begin
      errors++; $display("FAIL write_launch: got %h expected %h", {spi_en, spi_wr_ctrl, spi_sdata}, {1'b1, 1'b0, 16'hA55A});
    end
    wait_csn_low(seen);
    checks++;
    if (!seen || spi_en !== 1'b1) begin
      errors++; $display("FAIL write_en_hold: got csn_seen=%0d en=%b expected 1/1", seen, spi_en);
    end
    @(negedge sys_clk);
    checks++;
    if (spi_en !== 1'b0) begin errors++; $display("FAIL write_en_drop: got %b expected 0", spi_en); end
    wait_rsps(1, 200);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 18'h0) begin
      errors++; $display("FAIL write_rsp: got n=%0d first=%h expected n=1 0", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 18'h3ffff);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_read();
    obs_q.delete(); frame_q.delete();
    rd_src_q.push_back(16'h3C96);
    push_cmd(1'b1, 16'hFFFF);
    @(negedge sys_clk);
    checks++;
    if ({spi_en, spi_wr_ctrl, spi_sdata} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL read_launch: got %h expected %h", {spi_en, spi_wr_ctrl, spi_sdata}, {1'b1, 1'b1, 16'h0000});
    end
    wait_rsps(1, 200);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 1'b1, 16'h3C96}) begin
      errors++; $display("FAIL read_rsp: got n=%0d first=%h expected n=1 %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 18'h3ffff, {1'b0, 1'b1, 16'h3C96});
    end
  endtask

  task automatic test_fifo_full();
    logic [16:0] cmds[5];
    logic [17:0] exp_q[$];
    logic [16:0] exp_f[$];
    int f0;
    cmds = '{17'h0_1111, 17'h1_BEEF, 17'h0_2222, 17'h1_BEEF, 17'h0_3333};
    obs_q.delete(); frame_q.delete();
    rd_src_q.push_back(16'h4444); rd_src_q.push_back(16'h5555);
    exp_q = '{{2'b00, 16'h0000}, {2'b01, 16'h4444}, {2'b00, 16'h0000}, {2'b01, 16'h5555}, {2'b00, 16'h0000}};
    exp_f = '{17'h0_1111, 17'h1_0000, 17'h0_2222, 17'h1_0000, 17'h0_3333};
    f0 = frames;
    stub_xfer_len = 20;
    ready_bad = 0; ready_low = 0; occ_chk = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(cmds[i][16], cmds[i][15:0]);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %b expected 0", cmd_ready); end
    wait_rsps(5, 1000);
    occ_chk = 1'b0;
    checks++;
    if (ready_bad != 0 || ready_low == 0) begin
      errors++; $display("FAIL fifo_ready_track: got bad=%0d low=%0d expected bad=0 low>0", ready_bad, ready_low);
    end
    checks++;
    if (obs_q.size() != 5) begin errors++; $display("FAIL fifo_rsp_count: got %0d expected 5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fifo_rsp_%0d: got %h expected %h", i, i < obs_q.size() ? obs_q[i] : 18'h3ffff, exp_q[i]);
      end
    end
    checks++;
    if (frames - f0 != 5) begin errors++; $display("FAIL fifo_frames: got %0d expected 5", frames - f0); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= frame_q.size() || frame_q[i] !== exp_f[i]) begin
        errors++; $display("FAIL fifo_frame_%0d: got %h expected %h", i, i < frame_q.size() ? frame_q[i] : 17'h1ffff, exp_f[i]);
      end
    end
    stub_xfer_len = 5;
  endtask

  task automatic test_done_hold();
    int f0;
    obs_q.delete();
    f0 = frames;
    stub_done_len = 3;
    push_cmd(1'b0, 16'h0F0F);
    wait_rsps(1, 200);
    repeat (10) @(negedge sys_clk);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 18'h0) begin
      errors++; $display("FAIL done_hold_rsp: got n=%0d first=%h expected n=1 0", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 18'h3ffff);
    end
    checks++;
    if (frames - f0 != 1) begin errors++; $display("FAIL done_hold_frames: got %0d expected 1", frames - f0); end
    stub_done_len = 1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int r0, k;
    obs_q.delete();
    rd_src_q.push_back(16'h5AA5);
    push_cmd(1'b1, 16'h0000);
    wait_rsps(1, 200);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 1'b1, 16'h5AA5}) begin
      errors++; $display("FAIL rstmid_pre_rsp: got n=%0d first=%h expected n=1 %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 18'h3ffff, {1'b0, 1'b1, 16'h5AA5});
    end
    obs_q.delete();
    stub_xfer_len = 20;
    rd_src_q.push_back(16'h7777);
    push_cmd(1'b1, 16'h0000);
    push_cmd(1'b0, 16'h9999);
    wait_csn_low(seen);
    repeat (2) @(negedge sys_clk);
    checks++;
    if (!seen || busy !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got csn_seen=%0d busy=%b expected 1/1", seen, busy); end
    rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({spi_en, spi_wr_ctrl, spi_sdata} !== 18'h0) begin
      errors++; $display("FAIL rstmid_spi_out: got %h expected 0", {spi_en, spi_wr_ctrl, spi_sdata});
    end
    checks++;
    if ({rsp_valid, rsp_rd, rsp_err, rsp_data} !== 19'h0) begin
      errors++; $display("FAIL rstmid_rsp_out: got %h expected 0", {rsp_valid, rsp_rd, rsp_err, rsp_data});
    end
    checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid_busy_ready: got %b expected 01", {busy, cmd_ready});
    end
    rst = 1'b0;
    r0 = en_rises;
    k = 0;
    while (stub_busy && k < 200) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (10) @(negedge sys_clk);
    checks++;
    if (obs_q.size() != 0 || en_rises != r0) begin
      errors++; $display("FAIL rstmid_quiet: got rsps=%0d launches=%0d expected 0/0", obs_q.size(), en_rises - r0);
    end
    stub_xfer_len = 5;
  endtask

  task automatic test_timeout();
    int f0, k;
    obs_q.delete(); frame_q.delete();
    f0 = frames;
    stub_hang = 1'b1;
    push_cmd(1'b1, 16'h1234);
    push_cmd(1'b0, 16'h2222);
    k = 0;
    while (spi_en !== 1'b0 && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    stub_hang = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL timeout_err_pulse: got %h expected %h", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 16'h0000});
    end
    @(negedge sys_clk);
    checks++;
    if (last_en_len != TO) begin errors++; $display("FAIL timeout_en_len: got %0d expected %0d", last_en_len, TO); end
    wait_rsps(2, 400);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {1'b1, 1'b1, 16'h0000} || obs_q[1] !== 18'h0) begin
      errors++; $display("FAIL timeout_rsps: got n=%0d %h %h expected n=2 %h %h", obs_q.size(),
        obs_q.size() > 0 ? obs_q[0] : 18'h3ffff, obs_q.size() > 1 ? obs_q[1] : 18'h3ffff, {1'b1, 1'b1, 16'h0000}, 18'h0);
    end
    checks++;
    if (frames - f0 != 1 || frame_q.size() != 1 || frame_q[0] !== 17'h0_2222) begin
      errors++; $display("FAIL timeout_next_frame: got n=%0d %h expected n=1 %h", frames - f0, frame_q.size() > 0 ? frame_q[0] : 17'h1ffff, 17'h0_2222);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_data = 16'h0000;
    @(negedge sys_clk);
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_done_hold();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
